modinv_sched: RTL and testbench
===============================

// Module: modinv_sched
// PURPOSE
//  Round-robin scheduler that shares one modular-inverse core (a^-1 mod p, en/rdy protocol) between NREQ requesters.
//  Typical clients are the DSA sign path (k^-1 mod q) and the verify path (s^-1 mod q).
//  Per operation: validates operands, sequences the core's en (low = load, high = run), bounds run time with a watchdog,
//  returns the result with a one-cycle done pulse to the winning requester.
// PARAMETERS
//  SIZE     256   operand/result width in bits; must match the core
//  NREQ     2     number of requesters (2..8)
//  TIMEOUT  8192  max cycles with core_en=1 before abort; must be < 2^16
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous active-low reset
//  req       in   NREQ       request i; held high, operands stable, until done[i]
//  a_in      in   NREQ*SIZE  operand a for requester i at bits [i*SIZE +: SIZE]
//  p_in      in   NREQ*SIZE  modulus p for requester i at bits [i*SIZE +: SIZE]
//  gnt       out  NREQ       one-hot; owner of the current operation
//  busy      out  1          high in any state other than IDLE
//  done      out  NREQ       one-cycle pulse to the owner; res/err valid in that cycle
//  res       out  SIZE       inverse; held until the next done
//  err       out  1          qualifies done: 1 = invalid operands or timeout, res=0
//  core_a    out  SIZE       core operand a (registered)
//  core_p    out  SIZE       core modulus p (registered)
//  core_en   out  1          core enable; low holds the core in load/reset
//  core_rdy  in   1          core result valid
//  core_b    in   SIZE       core result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; gnt, done, err, busy, core_en = 0; res, core_a, core_p = 0; rr_ptr=NREQ-1.
//  FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE; LOAD -> DONE on invalid operands.
//  IDLE:
//   - If any req is set, pick the first set bit searching upward from rr_ptr+1, mod NREQ.
//   - Set gnt, latch that requester's a/p into core_a/core_p, go to LOAD.
//   - No request: stay in IDLE.
//  LOAD (1 cycle, core_en=0, so the core loads its operands):
//   - Invalid if a==0, p[0]==0, p<3, or a>=p.
//   - Invalid: err<=1, res<=0, go to DONE without running the core.
//   - Valid: core_en<=1, clear the watchdog, go to RUN.
//  RUN:
//   - core_en=1; the watchdog counts every cycle.
//   - On core_rdy=1: res<=core_b, err<=0, go to DONE.
//   - If the watchdog reaches TIMEOUT-1 without rdy: err<=1, res<=0, go to DONE.
//   - rdy takes priority when rdy and the timeout occur in the same cycle.
//  DONE (1 cycle):
//   - done[g]=1, core_en<=0, rr_ptr<=g.
//   - gnt clears when leaving DONE; go to IDLE.
//  Latency for a valid op: req high at edge N (IDLE) -> core_en high from N+2 -> done in the cycle after rdy is sampled.
//  Invalid op: done asserted at N+2.
//  Arbitration: the scheduler always returns to IDLE for one cycle between operations.
//   - A requester that keeps req high after its done cannot win twice in a row while another req is pending.
//  req deasserted mid-operation: the operation is not cancelled; it still completes and pulses done.
//  req changes on non-owners never affect the operation in flight.
//  core_rdy outside RUN is ignored.
//  core_en is low in every state except RUN, so the core restarts cleanly for each operation.
//  rst_n asserted mid-operation: immediate return to reset values; core_en=0 aborts the core; no done pulse.
// TESTING
//  1. Single op:
//     - req[0] with a=3, p=7; core model returns 5 after 40 cycles.
//     - Expect done[0] and res=5, err=0; core_en high for exactly 40+ cycles; gnt=01.
//  2. Contention:
//     - req=11 held from reset with four valid ops queued.
//     - Expect grant order 0,1,0,1; each done pulses one cycle; one idle cycle between operations.
//  3. Invalid operands:
//     - a=0 (p=11); a=11 (p=11); p=10 (a=3).
//     - Each gives done at N+2, err=1, res=0, core_en never rises.
//  4. Timeout:
//     - Core model never asserts rdy; TIMEOUT=16.
//     - Expect err=1 and res=0 with done after 16 RUN cycles; the next request is served normally.
//  5. Reset mid-run:
//     - Drop rst_n 10 cycles into RUN.
//     - Outputs go to reset values asynchronously; no done; after release, req[0] wins first.
//  6. Full-width:
//     - SIZE=256, p = 2^255-19, a = 2.
//     - res*2 mod p == 1 and matches the software reference.

Source files
------------

// File: rtl/modinv_sched.sv
// Round-robin scheduler sharing one modular-inverse core among NREQ requesters.
// Validates operands, sequences core_en, bounds run time with a watchdog.
module modinv_sched #(
   parameter int SIZE    = 256,
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 8192
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*SIZE-1:0] a_in,
   input  logic [NREQ*SIZE-1:0] p_in,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic [NREQ-1:0]      done,
   output logic [SIZE-1:0]      res,
   output logic                 err,
   output logic [SIZE-1:0]      core_a,
   output logic [SIZE-1:0]      core_p,
   output logic                 core_en,
   input  logic                 core_rdy,
   input  logic [SIZE-1:0]      core_b
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] owner;
   logic [PW-1:0] pick;
   logic          found;
   logic [15:0]   wd;
   logic          op_ok;
   int            idx;

   // First pending request strictly after the last owner, wrapping around.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   assign op_ok = (core_a != '0) && core_p[0] && (core_p >= SIZE'(3)) && (core_a < core_p);

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE) ? gnt : '0;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         gnt     <= '0;
         err     <= 1'b0;
         core_en <= 1'b0;
         res     <= '0;
         core_a  <= '0;
         core_p  <= '0;
         rr_ptr  <= PW'(NREQ - 1);
         owner   <= '0;
         wd      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  gnt        <= '0;
                  gnt[pick]  <= 1'b1;
                  owner      <= pick;
                  core_a     <= a_in[pick*SIZE +: SIZE];
                  core_p     <= p_in[pick*SIZE +: SIZE];
                  state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (op_ok) begin
                  core_en <= 1'b1;
                  wd      <= '0;
                  state   <= S_RUN;
               end else begin
                  err   <= 1'b1;
                  res   <= '0;
                  state <= S_DONE;
               end
            end
            S_RUN: begin
               // rdy wins over a simultaneous watchdog expiry.
               if (core_rdy) begin
                  res     <= core_b;
                  err     <= 1'b0;
                  core_en <= 1'b0;
                  state   <= S_DONE;
               end else if (wd == 16'(TIMEOUT - 1)) begin
                  res     <= '0;
                  err     <= 1'b1;
                  core_en <= 1'b0;
                  state   <= S_DONE;
               end else begin
                  wd <= wd + 16'd1;
               end
            end
            default: begin
               core_en <= 1'b0;
               rr_ptr  <= owner;
               gnt     <= '0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_modinv_sched.sv
// Self-checking bench for modinv_sched: behavioural core model, round-robin
// reference and extended-Euclid inverse reference; two instances (long / short watchdog).
module tb_modinv_sched;

   localparam int SIZE = 256;
   localparam int NREQ = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, rst_n1;
   logic [NREQ-1:0]      req0, req1;
   logic [NREQ*SIZE-1:0] a0, p0, a1, p1;
   logic [NREQ-1:0]      gnt0, gnt1, done0, done1;
   logic                 busy0, busy1, err0, err1, en0, en1, rdy0, rdy1;
   logic [SIZE-1:0]      res0, res1, ca0, cp0, ca1, cp1, cb0, cb1;

   int lat0 = 5, lat1 = 5, cnt0, cnt1;
   bit never1 = 1'b0;
   int cur = 0;

   int checks = 0;
   int failures = 0;

   modinv_sched #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(64)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .a_in(a0), .p_in(p0),
      .gnt(gnt0), .busy(busy0), .done(done0), .res(res0), .err(err0),
      .core_a(ca0), .core_p(cp0), .core_en(en0), .core_rdy(rdy0), .core_b(cb0));

   modinv_sched #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(16)) dut1 (
      .clk(clk), .rst_n(rst_n1), .req(req1), .a_in(a1), .p_in(p1),
      .gnt(gnt1), .busy(busy1), .done(done1), .res(res1), .err(err1),
      .core_a(ca1), .core_p(cp1), .core_en(en1), .core_rdy(rdy1), .core_b(cb1));

   // Extended Euclid with coefficients kept in [0, p); 0 when not invertible.
   function automatic logic [SIZE-1:0] ref_inv(input logic [SIZE-1:0] a, input logic [SIZE-1:0] p);
      logic [SIZE-1:0]   r0, r1, t0, t1, q, rn, tn, qm;
      logic [2*SIZE-1:0] qt;
      if (p == '0 || a == '0) return '0;
      r0 = p; r1 = a % p; t0 = '0; t1 = 1;
      while (r1 != '0) begin
         q  = r0 / r1;
         rn = r0 - q * r1;
         r0 = r1; r1 = rn;
         qt = ({{SIZE{1'b0}}, q} * {{SIZE{1'b0}}, t1}) % {{SIZE{1'b0}}, p};
         qm = qt[SIZE-1:0];
         tn = (t0 >= qm) ? t0 - qm : t0 + (p - qm);
         t0 = t1; t1 = tn;
      end
      return (r0 == 1) ? t0 : '0;
   endfunction

   function automatic bit bad_ops(input logic [SIZE-1:0] a, input logic [SIZE-1:0] p);
      return (a == '0) || !p[0] || (p < 3) || (a >= p);
   endfunction

   // Core models: rdy after lat cycles of core_en, restart whenever core_en drops.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cnt0 <= 0; else cnt0 <= en0 ? cnt0 + 1 : 0;
   always @(posedge clk or negedge rst_n1)
      if (!rst_n1) cnt1 <= 0; else cnt1 <= en1 ? cnt1 + 1 : 0;
   assign rdy0 = en0 && (cnt0 >= lat0);
   assign rdy1 = en1 && !never1 && (cnt1 >= lat1);
   always_comb cb0 = ref_inv(ca0, cp0);
   always_comb cb1 = ref_inv(ca1, cp1);

   wire [NREQ-1:0] done_c = (cur == 0) ? done0 : done1;
   wire [NREQ-1:0] gnt_c  = (cur == 0) ? gnt0  : gnt1;
   wire            busy_c = (cur == 0) ? busy0 : busy1;
   wire            err_c  = (cur == 0) ? err0  : err1;
   wire            en_c   = (cur == 0) ? en0   : en1;
   wire [SIZE-1:0] res_c  = (cur == 0) ? res0  : res1;

   task automatic check(input string tag, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int budget, output int owner, output int cyc, output int en_cyc,
                            output logic got_err, output logic [SIZE-1:0] got_res);
      bit ok;
      ok = 1'b0; owner = -1; cyc = 0; en_cyc = 0; got_err = 1'bx; got_res = 'x;
      while (cyc < budget && !ok) begin
         @(negedge clk);
         cyc++;
         if (en_c) en_cyc++;
         if (done_c != '0) begin
            ok      = 1'b1;
            owner   = done_c[1] ? 1 : 0;
            got_err = err_c;
            got_res = res_c;
            check("done_eq_gnt", done_c, gnt_c);
         end
      end
      check("done_seen", ok, 1);
   endtask

   task automatic set_op(input int inst, input int r, input logic [SIZE-1:0] a, input logic [SIZE-1:0] p);
      if (inst == 0) begin
         a0[r*SIZE +: SIZE] = a; p0[r*SIZE +: SIZE] = p; req0[r] = 1'b1;
      end else begin
         a1[r*SIZE +: SIZE] = a; p1[r*SIZE +: SIZE] = p; req1[r] = 1'b1;
      end
   endtask

   task automatic single(input int inst, input int r, input logic [SIZE-1:0] a, input logic [SIZE-1:0] p,
                         input int lat, input bit tmo, input string tag, output logic [SIZE-1:0] got_res);
      int own, cyc, enc, ecyc, eenc;
      logic ge;
      logic [SIZE-1:0] er;
      bit eb;
      cur = inst;
      eb  = bad_ops(a, p);
      if (inst == 0) lat0 = lat; else lat1 = lat;
      set_op(inst, r, a, p);
      wait_done(400, own, cyc, enc, ge, got_res);
      if (eb)       begin ecyc = 2;       eenc = 0;       er = '0; end
      else if (tmo) begin ecyc = 2 + 16;  eenc = 16;      er = '0; end
      else          begin ecyc = lat + 3; eenc = lat + 1; er = ref_inv(a, p); end
      check({tag, "_owner"}, own, r);
      check({tag, "_err"}, ge, eb || tmo);
      check({tag, "_res"}, got_res, er);
      check({tag, "_latency"}, cyc, ecyc);
      check({tag, "_en_cycles"}, enc, eenc);
      req0 = '0; req1 = '0;
      @(negedge clk);
      check({tag, "_idle"}, busy_c, 0);
      check({tag, "_done_1cyc"}, done_c, 0);
   endtask

   task automatic do_reset();
      req0 = '0; req1 = '0; a0 = '0; p0 = '0; a1 = '0; p1 = '0;
      rst_n = 1'b0; rst_n1 = 1'b0;
      #12;
      check("rst_gnt", gnt0, 0);   check("rst_busy", busy0, 0);
      check("rst_done", done0, 0); check("rst_err", err0, 0);
      check("rst_en", en0, 0);     check("rst_res", res0, 0);
      check("rst_core_a", ca0, 0); check("rst_core_p", cp0, 0);
      @(negedge clk);
      rst_n = 1'b1; rst_n1 = 1'b1;
      @(negedge clk);
   endtask

   logic [SIZE-1:0] r_res, pf, qa [2][2], qp [2][2];
   logic [2*SIZE-1:0] prod;
   int own, cyc, enc, last, exp_own, nxt [2];
   logic ge;

   initial begin
      do_reset();

      // Single op with a long core latency.
      single(0, 0, 3, 7, 40, 0, "single", r_res);
      check("single_res_const", r_res, 5);

      // Contention: both requesters hold req with two queued ops each.
      do_reset();
      cur = 0; lat0 = 7;
      qa[0][0] = 3;  qp[0][0] = 7;   qa[0][1] = 4;  qp[0][1] = 9;
      qa[1][0] = 10; qp[1][0] = 17;  qa[1][1] = 2;  qp[1][1] = 101;
      nxt[0] = 0; nxt[1] = 0; last = NREQ - 1;
      set_op(0, 0, qa[0][0], qp[0][0]);
      set_op(0, 1, qa[1][0], qp[1][0]);
      for (int n = 0; n < 4; n++) begin
         exp_own = -1;
         for (int k = 1; k <= NREQ; k++)
            if (exp_own < 0 && req0[(last + k) % NREQ]) exp_own = (last + k) % NREQ;
         wait_done(200, own, cyc, enc, ge, r_res);
         check("cont_owner", own, exp_own);
         check("cont_res", r_res, ref_inv(qa[exp_own][nxt[exp_own]], qp[exp_own][nxt[exp_own]]));
         check("cont_err", ge, 0);
         last = exp_own;
         nxt[exp_own]++;
         if (nxt[exp_own] < 2) set_op(0, exp_own, qa[exp_own][nxt[exp_own]], qp[exp_own][nxt[exp_own]]);
         else req0[exp_own] = 1'b0;
         @(negedge clk);
         check("cont_gap_idle", busy0, 0);
         check("cont_done_1cyc", done0, 0);
      end

      // Invalid operands never start the core.
      single(0, 0, 0, 11, 5, 0, "inv_a0", r_res);
      single(0, 1, 11, 11, 5, 0, "inv_age", r_res);
      single(0, 0, 3, 10, 5, 0, "inv_peven", r_res);

      // Watchdog abort, then a normal op on the same instance.
      never1 = 1'b1;
      single(1, 0, 3, 7, 5, 1, "tmo", r_res);
      never1 = 1'b0;
      single(1, 1, 5, 11, 5, 0, "after_tmo", r_res);
      check("after_tmo_const", r_res, 9);

      // Randomized ops under random contention.
      cur = 0; last = 0;
      for (int n = 0; n < 12; n++) begin
         logic [SIZE-1:0] ea [2], ep [2];
         int m;
         m = $urandom_range(1, 3);
         lat0 = $urandom_range(1, 20);
         for (int r = 0; r < NREQ; r++) begin
            logic [31:0] pv, av;
            pv = $urandom | 32'h3;
            av = 32'd1 + ($urandom % (pv - 32'd1));
            case ($urandom_range(0, 5))
               0:       av = 0;
               1:       av = pv;
               2:       pv = pv & ~32'h1;
               default: ;
            endcase
            ea[r] = SIZE'(av); ep[r] = SIZE'(pv);
            if (m[r]) set_op(0, r, ea[r], ep[r]);
         end
         exp_own = -1;
         for (int k = 1; k <= NREQ; k++)
            if (exp_own < 0 && m[(last + k) % NREQ]) exp_own = (last + k) % NREQ;
         wait_done(200, own, cyc, enc, ge, r_res);
         check("rnd_owner", own, exp_own);
         if (exp_own >= 0) begin
            check("rnd_err", ge, bad_ops(ea[exp_own], ep[exp_own]));
            check("rnd_res", r_res, bad_ops(ea[exp_own], ep[exp_own]) ? '0 : ref_inv(ea[exp_own], ep[exp_own]));
            last = exp_own;
         end
         req0 = '0;
         @(negedge clk);
         check("rnd_idle", busy0, 0);
      end

      // Reset mid-run: owner 0 finishes first so a non-reset pointer would favour 1.
      single(0, 0, 3, 7, 4, 0, "pre_rst", r_res);
      cur = 0; lat0 = 100;
      set_op(0, 1, 5, 11);
      enc = 0; cyc = 0;
      while (enc < 10 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (en0) enc++;
      end
      check("mid_run_reached", enc, 10);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_en", en0, 0);     check("mrst_gnt", gnt0, 0);
      check("mrst_busy", busy0, 0); check("mrst_done", done0, 0);
      check("mrst_res", res0, 0);   check("mrst_core_a", ca0, 0);
      lat0 = 3;
      set_op(0, 0, 3, 7);
      set_op(0, 1, 5, 11);
      @(negedge clk);
      check("mrst_no_done", done0, 0);
      rst_n = 1'b1;
      wait_done(100, own, cyc, enc, ge, r_res);
      check("mrst_first_owner", own, 0);
      check("mrst_first_res", r_res, 5);
      req0 = '0;
      @(negedge clk);

      // Full-width modulus 2^255-19, a = 2.
      pf = {1'b0, {(SIZE-1){1'b1}}} - SIZE'(18);
      single(0, 1, 2, pf, 10, 0, "fullw", r_res);
      prod = ({{SIZE{1'b0}}, r_res} * 2) % {{SIZE{1'b0}}, pf};
      check("fullw_times2", prod[SIZE-1:0], 1);
      check("fullw_half", r_res, (pf + SIZE'(1)) >> 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no_finish expected finish");
      $fatal(1, "bench time limit");
   end

endmodule
